sram_port_mem: RTL and testbench



---
 rtl/sram_port_mem.sv | 159 +++++++++++++++
 tb/tb_sram_port_mem.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_mem.sv
// Parametrised single-port word memory with byte strobes, req/gnt/rvalid handshake,
// post-reset zeroing and error responses. Optional counters: define MEM_PERF_CNT_EN.
module sram_port_mem #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 20,
   parameter int DEPTH  = 1024,
   parameter int RD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [DATA_W/8-1:0]   be_i,
   input  logic [ADDR_W-1:0]     addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   output logic                  gnt_o,
   output logic                  rvalid_o,
   output logic [DATA_W-1:0]     rdata_o,
   output logic                  err_o
`ifdef MEM_PERF_CNT_EN
   ,
   output logic [31:0]           rd_cnt_o,
   output logic [31:0]           wr_cnt_o
`endif
);

   localparam int BE_W  = DATA_W / 8;
   localparam int OFF_W = $clog2(BE_W);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

   state_t                state_r;
   logic [IDX_W-1:0]      init_idx_r;
   logic [DATA_W-1:0]     mem_r [DEPTH];

   logic                  pipe_rv_r   [RD_LAT];
   logic                  pipe_err_r  [RD_LAT];
   logic [DATA_W-1:0]     pipe_data_r [RD_LAT];

   logic [ADDR_W-1:0]     off_mask_s;
   logic [ADDR_W-1:0]     widx_s;
   logic [IDX_W-1:0]      idx_s;
   logic                  misalign_s;
   logic                  range_err_s;
   logic                  err_s;
   logic                  accept_s;
   logic                  wr_ok_s;
   logic                  rd_ok_s;

   // Address decode and request classification
   always_comb begin
      off_mask_s  = ~({ADDR_W{1'b1}} << OFF_W);
      misalign_s  = |(addr_i & off_mask_s);
      widx_s      = addr_i >> OFF_W;
      range_err_s = ({1'b0, widx_s} >= (ADDR_W + 1)'(DEPTH));
      idx_s       = widx_s[IDX_W-1:0];
      err_s       = misalign_s | range_err_s;
      gnt_o       = (state_r == ST_READY);
      accept_s    = req_i & gnt_o;
      wr_ok_s     = accept_s & we_i & ~err_s;
      rd_ok_s     = accept_s & ~we_i & ~err_s;
   end

   // Init/ready state machine; INIT walks every word index once
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_INIT;
         init_idx_r <= '0;
      end else begin
         case (state_r)
            ST_INIT: begin
               if (init_idx_r == IDX_W'(DEPTH - 1)) begin
                  state_r    <= ST_READY;
                  init_idx_r <= '0;
               end else begin
                  init_idx_r <= init_idx_r + IDX_W'(1);
               end
            end
            ST_READY: begin
               state_r    <= ST_READY;
               init_idx_r <= '0;
            end
            default: begin
               state_r    <= ST_INIT;
               init_idx_r <= '0;
            end
         endcase
      end
   end

   // Storage array: zeroing during INIT, byte-strobed writes when ready
   always_ff @(posedge clk) begin
      if (!rst && state_r == ST_INIT) begin
         mem_r[init_idx_r] <= '0;
      end else if (!rst && wr_ok_s) begin
         for (int b = 0; b < BE_W; b++) begin
            if (be_i[b]) begin
               mem_r[idx_s][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
   end

   // Response pipeline; stage 0 samples the array at the accepting edge
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_rv_r[i]   <= 1'b0;
            pipe_err_r[i]  <= 1'b0;
            pipe_data_r[i] <= '0;
         end
      end else begin
         pipe_rv_r[0]   <= rd_ok_s;
         pipe_err_r[0]  <= accept_s & err_s;
         pipe_data_r[0] <= rd_ok_s ? mem_r[idx_s] : '0;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_rv_r[i]   <= pipe_rv_r[i-1];
            pipe_err_r[i]  <= pipe_err_r[i-1];
            pipe_data_r[i] <= pipe_data_r[i-1];
         end
      end
   end

   // Outputs come straight from the last pipeline stage
   always_comb begin
      rvalid_o = pipe_rv_r[RD_LAT-1];
      err_o    = pipe_err_r[RD_LAT-1];
      rdata_o  = pipe_data_r[RD_LAT-1];
   end

`ifdef MEM_PERF_CNT_EN
   logic [31:0] rd_cnt_r;
   logic [31:0] wr_cnt_r;

   // Saturating counters of accepted legal reads and writes
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt_r <= 32'd0;
         wr_cnt_r <= 32'd0;
      end else begin
         if (rd_ok_s && rd_cnt_r != 32'hFFFF_FFFF) begin
            rd_cnt_r <= rd_cnt_r + 32'd1;
         end else begin
            rd_cnt_r <= rd_cnt_r;
         end
         if (wr_ok_s && wr_cnt_r != 32'hFFFF_FFFF) begin
            wr_cnt_r <= wr_cnt_r + 32'd1;
         end else begin
            wr_cnt_r <= wr_cnt_r;
         end
      end
   end

   assign rd_cnt_o = rd_cnt_r;
   assign wr_cnt_o = wr_cnt_r;
`endif

endmodule

// File: tb/tb_sram_port_mem.sv
// Bench for sram_port_mem: RD_LAT=1 and RD_LAT=3 instances share stimulus; a
// vector table plus hand sequences feed per-instance expected-response queues.
module tb_sram_port_mem;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  be = 4'h0;
   logic [19:0] addr = 20'h0;
   logic [31:0] wdata = 32'h0;

   logic        gnt1, rv1, err1;
   logic [31:0] rd1;
   logic        gnt3, rv3, err3;
   logic [31:0] rd3;
`ifdef MEM_PERF_CNT_EN
   logic [31:0] rdc1, wrc1, rdc3, wrc3;
`endif

   always #5 clk = ~clk;

   sram_port_mem #(.DATA_W(32), .ADDR_W(20), .DEPTH(DEPTH), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
      .wdata_i(wdata), .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rd1), .err_o(err1)
`ifdef MEM_PERF_CNT_EN
      , .rd_cnt_o(rdc1), .wr_cnt_o(wrc1)
`endif
   );

   sram_port_mem #(.DATA_W(32), .ADDR_W(20), .DEPTH(DEPTH), .RD_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
      .wdata_i(wdata), .gnt_o(gnt3), .rvalid_o(rv3), .rdata_o(rd3), .err_o(err3)
`ifdef MEM_PERF_CNT_EN
      , .rd_cnt_o(rdc3), .wr_cnt_o(wrc3)
`endif
   );

   typedef struct {
      int          due;
      logic        rv;
      logic        er;
      logic [31:0] data;
   } resp_t;

   typedef struct {
      logic        w;
      logic [3:0]  b;
      logic [19:0] a;
      logic [31:0] d;
      logic        xrv;
      logic        xer;
      logic [31:0] xd;
   } vec_t;

   resp_t q1[$];
   resp_t q3[$];
   resp_t e1, e3;
   vec_t  vecs[26];
   int    cyc = 0;
   int    rst_edge = 0;
   int    total = 0;
   int    bad = 0;
   int    exp_rd = 0;
   int    exp_wr = 0;
   bit    chk_en = 1'b0;
   logic  exp_g;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Every cycle: response and grant of both instances against expectations
   always @(negedge clk) begin
      if (chk_en) begin
         e1 = '{0, 1'b0, 1'b0, 32'h0};
         e3 = '{0, 1'b0, 1'b0, 32'h0};
         if (q1.size() > 0 && q1[0].due == cyc) e1 = q1.pop_front();
         if (q3.size() > 0 && q3[0].due == cyc) e3 = q3.pop_front();
         cmp("resp_lat1 {rvalid,err,rdata}", {30'h0, rv1, err1, rd1}, {30'h0, e1.rv, e1.er, e1.data});
         cmp("resp_lat3 {rvalid,err,rdata}", {30'h0, rv3, err3, rd3}, {30'h0, e3.rv, e3.er, e3.data});
         exp_g = ((cyc - rst_edge) >= DEPTH);
         cmp("gnt_lat1", {63'h0, gnt1}, {63'h0, exp_g});
         cmp("gnt_lat3", {63'h0, gnt3}, {63'h0, exp_g});
      end
   end

   task automatic drive(input logic w, input logic [3:0] b, input logic [19:0] a,
                        input logic [31:0] d, input logic xrv, input logic xer,
                        input logic [31:0] xd);
      resp_t r;
      @(negedge clk); #1;
      req = 1'b1; we = w; be = b; addr = a; wdata = d;
      if (xrv || xer) begin
         r = '{cyc + 1, xrv, xer, xd};
         q1.push_back(r);
         r.due = cyc + 3;
         q3.push_back(r);
      end
      if (!xer) begin
         if (w) exp_wr++;
         else   exp_rd++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk); #1;
         req = 1'b0;
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk); #1;
      rst = 1'b1;
      req = 1'b0;
      rst_edge = cyc + n;
      q1.delete();
      q3.delete();
      exp_rd = 0;
      exp_wr = 0;
      repeat (n) @(negedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic check_counters(input string tag);
`ifdef MEM_PERF_CNT_EN
      cmp({tag, " rd_cnt_lat1"}, {32'h0, rdc1}, {32'h0, 32'(exp_rd)});
      cmp({tag, " wr_cnt_lat1"}, {32'h0, wrc1}, {32'h0, 32'(exp_wr)});
      cmp({tag, " rd_cnt_lat3"}, {32'h0, rdc3}, {32'h0, 32'(exp_rd)});
      cmp({tag, " wr_cnt_lat3"}, {32'h0, wrc3}, {32'h0, 32'(exp_wr)});
`endif
   endtask

   initial begin
      //          we    be    addr        wdata          rv    err   rdata
      vecs[0]  = '{1'b0, 4'hF, 20'h00000, 32'h00000000, 1'b1, 1'b0, 32'h00000000};
      vecs[1]  = '{1'b1, 4'hF, 20'h00004, 32'h00000003, 1'b0, 1'b0, 32'h00000000};
      vecs[2]  = '{1'b0, 4'hF, 20'h00004, 32'h00000000, 1'b1, 1'b0, 32'h00000003};
      vecs[3]  = '{1'b1, 4'hF, 20'h00008, 32'h0000000F, 1'b0, 1'b0, 32'h00000000};
      vecs[4]  = '{1'b0, 4'hF, 20'h00008, 32'h00000000, 1'b1, 1'b0, 32'h0000000F};
      vecs[5]  = '{1'b1, 4'hF, 20'h0000C, 32'hAABBCCDD, 1'b0, 1'b0, 32'h00000000};
      vecs[6]  = '{1'b1, 4'h5, 20'h0000C, 32'h11223344, 1'b0, 1'b0, 32'h00000000};
      vecs[7]  = '{1'b0, 4'h0, 20'h0000C, 32'h00000000, 1'b1, 1'b0, 32'hAA22CC44};
      vecs[8]  = '{1'b0, 4'hF, 20'h00006, 32'h00000000, 1'b0, 1'b1, 32'h00000000};
      vecs[9]  = '{1'b1, 4'hF, 20'h01000, 32'hDEADBEEF, 1'b0, 1'b1, 32'h00000000};
      vecs[10] = '{1'b0, 4'hF, 20'h00004, 32'h00000000, 1'b1, 1'b0, 32'h00000003};
      vecs[11] = '{1'b1, 4'h0, 20'h00010, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000};
      vecs[12] = '{1'b0, 4'hF, 20'h00010, 32'h00000000, 1'b1, 1'b0, 32'h00000000};
      vecs[13] = '{1'b0, 4'hF, 20'h00004, 32'h00000000, 1'b1, 1'b0, 32'h00000003};
      vecs[14] = '{1'b0, 4'hF, 20'h00008, 32'h00000000, 1'b1, 1'b0, 32'h0000000F};
      vecs[15] = '{1'b0, 4'hF, 20'h0000C, 32'h00000000, 1'b1, 1'b0, 32'hAA22CC44};
      vecs[16] = '{1'b1, 4'hF, 20'h00FFC, 32'h12345678, 1'b0, 1'b0, 32'h00000000};
      vecs[17] = '{1'b0, 4'hF, 20'h00FFC, 32'h00000000, 1'b1, 1'b0, 32'h12345678};
      vecs[18] = '{1'b0, 4'hF, 20'h00FFE, 32'h00000000, 1'b0, 1'b1, 32'h00000000};
      vecs[19] = '{1'b1, 4'h2, 20'h00014, 32'h5555AB55, 1'b0, 1'b0, 32'h00000000};
      vecs[20] = '{1'b0, 4'hF, 20'h00014, 32'h00000000, 1'b1, 1'b0, 32'h0000AB00};
      vecs[21] = '{1'b0, 4'hF, 20'hFFFFC, 32'h00000000, 1'b0, 1'b1, 32'h00000000};
      vecs[22] = '{1'b1, 4'hF, 20'h00FFD, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000000};
      vecs[23] = '{1'b0, 4'hF, 20'h00FFC, 32'h00000000, 1'b1, 1'b0, 32'h12345678};
      vecs[24] = '{1'b1, 4'hF, 20'h00400, 32'h0BADF00D, 1'b1 ^ 1'b1, 1'b0, 32'h00000000};
      vecs[25] = '{1'b0, 4'hF, 20'h00000, 32'h00000000, 1'b1, 1'b0, 32'h00000000};

      do_reset(3);
      chk_en = 1'b1;
      check_counters("after reset");
      idle(DEPTH - 1);

      foreach (vecs[i]) begin
         drive(vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].d, vecs[i].xrv, vecs[i].xer, vecs[i].xd);
      end
      idle(6);
      check_counters("after table");

      // Two reads in flight when rst pulses: their responses must vanish
      drive(1'b0, 4'hF, 20'h00004, 32'h0, 1'b1, 1'b0, 32'h00000003);
      drive(1'b0, 4'hF, 20'h00008, 32'h0, 1'b1, 1'b0, 32'h0000000F);
      do_reset(1);
      check_counters("mid reset");
      idle(DEPTH - 1);

      // Memory was re-zeroed; counters restart from zero
      drive(1'b0, 4'hF, 20'h00004, 32'h0, 1'b1, 1'b0, 32'h00000000);
      drive(1'b0, 4'hF, 20'h0000C, 32'h0, 1'b1, 1'b0, 32'h00000000);
      drive(1'b0, 4'hF, 20'h00006, 32'h0, 1'b0, 1'b1, 32'h00000000);
      drive(1'b1, 4'h1, 20'h00004, 32'h000000A5, 1'b0, 1'b0, 32'h00000000);
      drive(1'b0, 4'hF, 20'h00004, 32'h0, 1'b1, 1'b0, 32'h000000A5);
      idle(6);
      check_counters("after re-init");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
